charmatrix_cmd_parser: RTL and testbench

- Sits between the UART receiver and the character/colour buffers of the LED char-matrix display.
- Consumes received bytes over a valid/ready handshake and interprets a small control protocol: printable characters, carriage return, backspace, and ESC sequences for colour, random-colour mode and clear.
- Produces single-cycle write strobes (address, character, colour) into the text/colour buffer that the LED refresh engine reads.

---
 rtl/charmatrix_cmd_parser_pkg.sv | 25 ++
 rtl/charmatrix_cmd_parser_hex_nibble_decoder.sv | 23 ++
 rtl/charmatrix_cmd_parser.sv | 172 +++++++++++++++++
 tb/tb_charmatrix_cmd_parser.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/charmatrix_cmd_parser_pkg.sv
// Shared constants, state encoding and byte-class helper for the char-matrix command parser.
package charmatrix_pkg;

  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_ESC   = 8'h1B;
  localparam logic [7:0] CMD_COLOR = 8'h43;  // 'C'
  localparam logic [7:0] CMD_RAND  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CLEAR = 8'h58;  // 'X'

  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;

  typedef enum logic [1:0] {
    S_CHAR  = 2'd0,
    S_ESC   = 2'd1,
    S_COLOR = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/charmatrix_cmd_parser_hex_nibble_decoder.sv
// Combinational ASCII hex digit decoder ('0'-'9', 'A'-'F', 'a'-'f').
// Zero latency; no handshake.
module hex_nibble_decoder (
  input  logic [7:0] byte_dat,
  output logic       hex_vld,
  output logic [3:0] hex_val
);

  always_comb begin
    hex_vld = 1'b0;
    hex_val = 4'h0;
    if (byte_dat >= 8'h30 && byte_dat <= 8'h39) begin
      hex_vld = 1'b1;
      hex_val = byte_dat[3:0];
    end else if ((byte_dat >= 8'h41 && byte_dat <= 8'h46) ||
                 (byte_dat >= 8'h61 && byte_dat <= 8'h66)) begin
      // 'A'..'F' and 'a'..'f' share the low nibble 1..6
      hex_vld = 1'b1;
      hex_val = byte_dat[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/charmatrix_cmd_parser.sv
// Byte-stream command parser feeding the LED char-matrix text/colour buffer.
// One-cycle registered write latency; rx_ready drops only while a clear sweep runs.
module charmatrix_cmd_parser
  import charmatrix_pkg::*;
#(
  parameter int          NUM_CHARS  = 4,
  parameter int          ADDR_W     = 2,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_error,
  output logic              rx_ready,
  input  logic [3:0]        rnd_color,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_char,
  output logic [3:0]        wr_color,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy
);

  localparam int CNT_W = $clog2(NUM_CHARS + 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CHARS - 1);
  localparam logic [CNT_W-1:0]  CLR_DONE  = CNT_W'(NUM_CHARS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d;
  logic [3:0]          cur_color_q, cur_color_d;
  logic                rand_mode_q, rand_mode_d;
  logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic                rx_ready_q, rx_ready_d;
  logic                busy_q, busy_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_char_q, wr_char_d;
  logic [3:0]          wr_color_q, wr_color_d;

  logic                hex_vld;
  logic [3:0]          hex_val;
  logic                accept;
  logic [3:0]          sel_color;

  hex_nibble_decoder u_hex (
    .byte_dat (rx_data),
    .hex_vld  (hex_vld),
    .hex_val  (hex_val)
  );

  assign accept    = rx_valid && rx_ready_q;
  assign sel_color = rand_mode_q ? rnd_color : cur_color_q;

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    cur_color_d = cur_color_q;
    rand_mode_d = rand_mode_q;
    clr_cnt_d   = clr_cnt_q;
    rx_ready_d  = 1'b1;
    busy_d      = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_char_d   = wr_char_q;
    wr_color_d  = wr_color_q;

    if (state_q == S_CLEAR) begin
      if (clr_cnt_q == CLR_DONE) begin
        state_d   = S_CHAR;
        cursor_d  = '0;
        clr_cnt_d = '0;
      end else begin
        wr_en_d    = 1'b1;
        wr_addr_d  = ADDR_W'(clr_cnt_q);
        wr_char_d  = CLEAR_CHAR;
        wr_color_d = sel_color;
        clr_cnt_d  = clr_cnt_q + CNT_W'(1);
        busy_d     = 1'b1;
        rx_ready_d = 1'b0;
      end
    end else if (accept) begin
      if (rx_error) begin
        // corrupted byte also aborts any half-received escape
        state_d = S_CHAR;
      end else begin
        case (state_q)
          S_CHAR: begin
            if (is_printable(rx_data)) begin
              wr_en_d    = 1'b1;
              wr_addr_d  = cursor_q;
              wr_char_d  = rx_data;
              wr_color_d = sel_color;
              cursor_d   = (cursor_q == LAST_CELL) ? '0 : cursor_q + ADDR_W'(1);
            end else if (rx_data == CHR_CR) begin
              cursor_d = '0;
            end else if (rx_data == CHR_BS) begin
              if (cursor_q != '0) cursor_d = cursor_q - ADDR_W'(1);
            end else if (rx_data == CHR_ESC) begin
              state_d = S_ESC;
            end
          end
          S_ESC: begin
            state_d = S_CHAR;
            if (rx_data == CMD_COLOR) begin
              state_d = S_COLOR;
            end else if (rx_data == CMD_RAND) begin
              rand_mode_d = 1'b1;
            end else if (rx_data == CHR_ESC) begin
              state_d = S_ESC;
            end else if (rx_data == CMD_CLEAR) begin
              // first clear write issues in the same cycle busy rises
              state_d    = S_CLEAR;
              wr_en_d    = 1'b1;
              wr_addr_d  = '0;
              wr_char_d  = CLEAR_CHAR;
              wr_color_d = sel_color;
              clr_cnt_d  = CNT_W'(1);
              busy_d     = 1'b1;
              rx_ready_d = 1'b0;
            end
          end
          S_COLOR: begin
            state_d = S_CHAR;
            if (hex_vld) begin
              cur_color_d = hex_val;
              rand_mode_d = 1'b0;
            end
          end
          default: state_d = S_CHAR;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CHAR;
      cursor_q    <= '0;
      cur_color_q <= 4'h0;
      rand_mode_q <= 1'b0;
      clr_cnt_q   <= '0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_char_q   <= 8'h00;
      wr_color_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      cur_color_q <= cur_color_d;
      rand_mode_q <= rand_mode_d;
      clr_cnt_q   <= clr_cnt_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_char_q   <= wr_char_d;
      wr_color_q  <= wr_color_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign busy     = busy_q;
  assign cursor   = cursor_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_char  = wr_char_q;
  assign wr_color = wr_color_q;

endmodule

// File: tb/tb_charmatrix_cmd_parser.sv
// Scoreboard bench for charmatrix_cmd_parser: expected writes queued at drive time, popped on wr_en.
module tb_charmatrix_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic       rx_ready;
  logic [3:0] rnd_color = 4'h0;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_char;
  logic [3:0] wr_color;
  logic [1:0] cursor;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [13:0] sb[$];

  charmatrix_cmd_parser #(.NUM_CHARS(4), .ADDR_W(2), .CLEAR_CHAR(8'h20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .rx_ready  (rx_ready),
    .rnd_color (rnd_color),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .wr_color  (wr_color),
    .cursor    (cursor),
    .busy      (busy)
  );

  always #25 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [7:0] c, input logic [3:0] col);
    sb.push_back({a, c, col});
  endtask

  // Drive one byte and hold it until it is accepted; returns 1 time unit after the accept edge.
  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    int waited;
    rx_data  = b;
    rx_error = err;
    rx_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!rx_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) chk("rdy_timeout", rx_ready, 1'b1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (sb.size() == 0) chk("unexp_wr", wr_en, 1'b0);
      else chk("wr", {18'h0, wr_addr, wr_char, wr_color}, {18'h0, sb.pop_front()});
    end
  end

  initial begin
    string s;
    #10;
    chk("rst_rdy",   rx_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr",    {wr_addr, wr_char, wr_color}, 0);
    chk("rst_cur",   cursor, 0);
    chk("rst_busy",  busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_rise", rx_ready, 1);

    // "AB" back-to-back
    push(0, 8'h41, 0);
    push(1, 8'h42, 0);
    send(8'h41);
    send(8'h42);
    chk("cur_AB", cursor, 2);

    // CR then "WXYZQ": wraps after cell 3
    send(8'h0D);
    chk("cur_cr", cursor, 0);
    s = "WXYZQ";
    for (int i = 0; i < 5; i++) push(2'(i % 4), s[i], 0);
    for (int i = 0; i < 5; i++) send(s[i]);
    chk("cur_wrap", cursor, 1);

    // ESC C a -> colour 10
    send(8'h1B); send(8'h43); send(8'h61);
    push(1, 8'h48, 4'hA);
    send(8'h48);
    // ESC C g -> ignored, colour stays 10
    send(8'h1B); send(8'h43); send(8'h67);
    push(2, 8'h49, 4'hA);
    send(8'h49);
    chk("cur_col", cursor, 3);

    // random-colour mode
    rnd_color = 4'h7;
    send(8'h1B); send(8'h52);
    push(3, 8'h4D, 4'h7);
    send(8'h4D);
    rnd_color = 4'h2;
    send(8'h1B); send(8'h43); send(8'h33);
    push(0, 8'h4E, 4'h3);
    send(8'h4E);
    chk("cur_rnd", cursor, 1);

    // full clear
    for (int i = 0; i < 4; i++) push(2'(i), 8'h20, 4'h3);
    send(8'h1B);
    send(8'h58);
    for (int i = 0; i < 4; i++) begin
      chk("clr_busy", busy, 1);
      chk("clr_rdy",  rx_ready, 0);
      @(posedge clk);
      #1;
    end
    chk("clr_done_busy", busy, 0);
    chk("clr_done_rdy",  rx_ready, 1);
    chk("clr_done_cur",  cursor, 0);

    // backspace saturates at 0
    send(8'h08);
    chk("bs_sat", cursor, 0);
    // errored byte aborts escape, 'C' then prints
    send(8'h1B);
    send(8'h5A, 1'b1);
    push(0, 8'h43, 4'h3);
    send(8'h43);
    push(1, 8'h44, 4'h3);
    send(8'h44);
    send(8'h08);
    chk("bs_dec", cursor, 1);

    // reset during second clear cycle
    push(0, 8'h20, 4'h3);
    send(8'h1B);
    send(8'h58);
    @(posedge clk);
    #1;
    chk("clr2_wr_en", wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy",  busy, 0);
    chk("mid_rst_rdy",   rx_ready, 0);
    chk("mid_rst_cur",   cursor, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", rx_ready, 1);
    rnd_color = 4'h9;
    push(0, 8'h41, 4'h0);
    send(8'h41);
    chk("post_rst_cur", cursor, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
